flit_word_serializer: RTL and testbench

FLIT_WORD_SERIALIZER -- requirements
Module: flit_word_serializer

---
 rtl/flit_word_serializer.sv | 131 +++++++++++++
 tb/tb_flit_word_serializer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_word_serializer.sv
// Buffers up to two D2D flits and streams each one to the SHA core one word at a time, word 0 first.
// Optional build macro FLIT_SER_BSWAP_EN byte-reverses every word driven on sha_din.
//
// state | meaning
// EMPTY | no flit buffered, nothing presented to the SHA core
// ONE   | one flit buffered, head flit being serialized
// FULL  | two flits buffered, flit_ready deasserted
module flit_word_serializer #(
  parameter int WORD_W = 32,
  parameter int FLIT_W = 512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FLIT_W-1:0] flit_data,
  input  logic              flit_valid,
  input  logic              flit_last,
  output logic              flit_ready,
  output logic [WORD_W-1:0] sha_din,
  output logic              sha_src_ready,
  input  logic              sha_src_read,
  output logic              sha_msg_last,
  output logic              busy
);

  localparam int WORDS = FLIT_W / WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [FLIT_W-1:0] data0_q, data0_d;
  logic [FLIT_W-1:0] data1_q, data1_d;
  logic              last0_q, last0_d;
  logic              last1_q, last1_d;

  logic              push;
  logic              consume;
  logic              pop;
  logic [FLIT_W-1:0] head_data;
  logic              head_last;
  logic [WORD_W-1:0] word_sel;
  logic [WORD_W-1:0] word_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      idx_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      last0_q  <= 1'b0;
      last1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      last0_q  <= last0_d;
      last1_q  <= last1_d;
    end
  end

  // Handshake outputs come from registered state only, so flit_ready never depends on sha_src_read.
  always_comb begin
    flit_ready    = (state_q != FULL);
    sha_src_ready = (state_q != EMPTY);
    busy          = sha_src_ready;
    push          = flit_valid && flit_ready;
    consume       = sha_src_read && sha_src_ready;
    pop           = consume && (idx_q == IDX_LAST);
  end

  always_comb begin
    head_data    = rd_ptr_q ? data1_q : data0_q;
    head_last    = rd_ptr_q ? last1_q : last0_q;
    word_sel     = head_data[idx_q*WORD_W +: WORD_W];
    word_out     = word_sel;
`ifdef FLIT_SER_BSWAP_EN
    for (int b = 0; b < WORD_W / 8; b++) begin
      word_out[b*8 +: 8] = word_sel[WORD_W - 8 - b*8 +: 8];
    end
`endif
    sha_din      = word_out;
    sha_msg_last = sha_src_ready && (idx_q == IDX_LAST) && head_last;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    data0_d  = data0_q;
    data1_d  = data1_q;
    last0_d  = last0_q;
    last1_d  = last1_q;

    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase

    if (consume) idx_d = pop ? '0 : idx_q + IDX_W'(1);

    if (push) begin
      if (wr_ptr_q) begin
        data1_d = flit_data;
        last1_d = flit_last;
      end else begin
        data0_d = flit_data;
        last0_d = flit_last;
      end
    end
  end

endmodule

// File: tb/tb_flit_word_serializer.sv
// Scoreboard bench for flit_word_serializer: accepted flits expand into expected words that are
// popped and compared as the SHA side consumes them.
module tb_flit_word_serializer;

  localparam int WORD_W = 32;
  localparam int FLIT_W = 512;
  localparam int WORDS  = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [FLIT_W-1:0] flit_data;
  logic              flit_valid;
  logic              flit_last;
  logic              flit_ready;
  logic [WORD_W-1:0] sha_din;
  logic              sha_src_ready;
  logic              sha_src_read;
  logic              sha_msg_last;
  logic              busy;

  typedef struct packed {
    logic [WORD_W-1:0] w;
    logic              l;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  logic              obs_push;
  logic              obs_cons;
  logic [WORD_W-1:0] obs_din;
  logic              obs_ml;

  flit_word_serializer #(.WORD_W(WORD_W), .FLIT_W(FLIT_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .flit_data     (flit_data),
    .flit_valid    (flit_valid),
    .flit_last     (flit_last),
    .flit_ready    (flit_ready),
    .sha_din       (sha_din),
    .sha_src_ready (sha_src_ready),
    .sha_src_read  (sha_src_read),
    .sha_msg_last  (sha_msg_last),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [WORD_W-1:0] exp_word(input logic [FLIT_W-1:0] d, input int k);
    logic [WORD_W-1:0] w;
    w = d[k*WORD_W +: WORD_W];
`ifdef FLIT_SER_BSWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  function automatic logic [FLIT_W-1:0] make_flit(input logic [WORD_W-1:0] base);
    logic [FLIT_W-1:0] d;
    for (int k = 0; k < WORDS; k++) d[k*WORD_W +: WORD_W] = base + WORD_W'(k);
    return d;
  endfunction

  function automatic logic [FLIT_W-1:0] rand_flit();
    logic [FLIT_W-1:0] d;
    for (int k = 0; k < WORDS; k++) d[k*WORD_W +: WORD_W] = $urandom;
    return d;
  endfunction

  // Drives one cycle of stimulus starting just after a rising edge, samples the DUT before the
  // next edge, and records an accepted flit in the scoreboard.
  task automatic step(input logic v, input logic [FLIT_W-1:0] d, input logic l, input logic r);
    flit_valid   = v;
    flit_data    = d;
    flit_last    = l;
    sha_src_read = r;
    #1;
    obs_push = v && flit_ready;
    obs_cons = r && sha_src_ready;
    obs_din  = sha_din;
    obs_ml   = sha_msg_last;
    if (obs_push)
      for (int k = 0; k < WORDS; k++) sb.push_back('{w: exp_word(d, k), l: (l && k == WORDS-1)});
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (flit_ready !== 1'b1) begin errors++; $display("FAIL reset_flit_ready: got %b want 1", flit_ready); end
    checks++;
    if (sha_src_ready !== 1'b0) begin errors++; $display("FAIL reset_src_ready: got %b want 0", sha_src_ready); end
    checks++;
    if (sha_msg_last !== 1'b0) begin errors++; $display("FAIL reset_msg_last: got %b want 0", sha_msg_last); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (sha_din !== '0) begin errors++; $display("FAIL reset_din: got %h want 0", sha_din); end
  endtask

  task automatic test_single_flit();
    logic [FLIT_W-1:0] d;
    d = make_flit(32'h0000_0100);
    step(1'b1, d, 1'b1, 1'b1);
    checks++;
    if (obs_push !== 1'b1) begin errors++; $display("FAIL single_push: got %b want 1", obs_push); end
    for (int i = 0; i < WORDS; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if (obs_cons !== 1'b1) begin
        errors++; $display("FAIL single_stream: word %0d not presented, src_ready=0", i);
      end else begin
        e = sb.pop_front();
        if (obs_din !== e.w || obs_ml !== e.l) begin
          errors++; $display("FAIL single_word: idx %0d got %h/%b want %h/%b", i, obs_din, obs_ml, e.w, e.l);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [FLIT_W-1:0] a, b, c;
    logic c_in;
    int   n_cons;
    int   n_held;
    a = rand_flit(); b = rand_flit(); c = rand_flit();
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    checks++;
    if (flit_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b want 0", flit_ready); end
    n_held = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, c, 1'b1, 1'b0);
      if (obs_push) n_held++;
    end
    checks++;
    if (n_held != 0) begin errors++; $display("FAIL b2b_hold: %0d pushes while full, want 0", n_held); end
    c_in = 1'b0;
    n_cons = 0;
    for (int cyc = 0; cyc < 80 && (sb.size() != 0 || !c_in); cyc++) begin
      step(!c_in, c, 1'b1, 1'b1);
      if (obs_push) begin
        c_in = 1'b1;
        checks++;
        if (n_cons != WORDS) begin errors++; $display("FAIL b2b_c_accept: accepted after %0d words want %0d", n_cons, WORDS); end
      end
      if (obs_cons) begin
        n_cons++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_order: extra word %h with empty scoreboard", obs_din);
        end else begin
          e = sb.pop_front();
          if (obs_din !== e.w || obs_ml !== e.l) begin
            errors++; $display("FAIL b2b_order: word %0d got %h/%b want %h/%b", n_cons-1, obs_din, obs_ml, e.w, e.l);
          end
        end
      end
    end
    checks++;
    if (!c_in || sb.size() != 0 || n_cons != 3*WORDS) begin
      errors++; $display("FAIL b2b_complete: c_in=%b left=%0d consumed=%0d want 1/0/%0d", c_in, sb.size(), n_cons, 3*WORDS);
    end
    sb.delete();
  endtask

  task automatic test_simul_push_pop();
    logic [FLIT_W-1:0] x, y;
    x = make_flit(32'h0000_0200);
    y = make_flit(32'h0000_0300);
    step(1'b1, x, 1'b0, 1'b1);
    for (int i = 0; i < WORDS-1; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (obs_cons) e = sb.pop_front();
    end
    step(1'b1, y, 1'b1, 1'b1);
    checks++;
    if (obs_push !== 1'b1 || obs_cons !== 1'b1) begin
      errors++; $display("FAIL simul_handshake: push=%b cons=%b want 1/1", obs_push, obs_cons);
    end else begin
      e = sb.pop_front();
      checks++;
      if (obs_din !== e.w || obs_ml !== e.l) begin
        errors++; $display("FAIL simul_word15: got %h/%b want %h/%b", obs_din, obs_ml, e.w, e.l);
      end
    end
    checks++;
    if (sha_src_ready !== 1'b1 || flit_ready !== 1'b1) begin
      errors++; $display("FAIL simul_count: src_ready=%b flit_ready=%b want 1/1", sha_src_ready, flit_ready);
    end
    checks++;
    if (sha_din !== exp_word(y, 0)) begin errors++; $display("FAIL simul_next_word0: got %h want %h", sha_din, exp_word(y, 0)); end
    for (int i = 0; i < WORDS; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if (!obs_cons || sb.size() == 0) begin
        errors++; $display("FAIL simul_drain: word %0d cons=%b left=%0d", i, obs_cons, sb.size());
      end else begin
        e = sb.pop_front();
        if (obs_din !== e.w || obs_ml !== e.l) begin
          errors++; $display("FAIL simul_drain: idx %0d got %h/%b want %h/%b", i, obs_din, obs_ml, e.w, e.l);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_read_empty();
    logic [FLIT_W-1:0] z;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if (obs_cons !== 1'b0 || sha_src_ready !== 1'b0) begin
        errors++; $display("FAIL empty_read: cons=%b src_ready=%b want 0/0", obs_cons, sha_src_ready);
      end
    end
    z = rand_flit();
    step(1'b1, z, 1'b1, 1'b0);
    for (int i = 0; i < WORDS; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if (!obs_cons || sb.size() == 0) begin
        errors++; $display("FAIL empty_restart: word %0d cons=%b left=%0d", i, obs_cons, sb.size());
      end else begin
        e = sb.pop_front();
        if (obs_din !== e.w || obs_ml !== e.l) begin
          errors++; $display("FAIL empty_restart: idx %0d got %h/%b want %h/%b", i, obs_din, obs_ml, e.w, e.l);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    logic [FLIT_W-1:0] w, n;
    w = rand_flit();
    step(1'b1, w, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (obs_cons) e = sb.pop_front();
    end
    sha_src_read = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (flit_ready !== 1'b1 || sha_src_ready !== 1'b0 || busy !== 1'b0 || sha_msg_last !== 1'b0 || sha_din !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: ready=%b src=%b busy=%b ml=%b din=%h want 1/0/0/0/0",
               flit_ready, sha_src_ready, busy, sha_msg_last, sha_din);
    end
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    n = rand_flit();
    step(1'b1, n, 1'b0, 1'b0);
    checks++;
    if (sha_din !== exp_word(n, 0)) begin errors++; $display("FAIL mid_reset_word0: got %h want %h", sha_din, exp_word(n, 0)); end
    for (int i = 0; i < WORDS; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if (!obs_cons || sb.size() == 0) begin
        errors++; $display("FAIL mid_reset_drain: word %0d cons=%b left=%0d", i, obs_cons, sb.size());
      end else begin
        e = sb.pop_front();
        if (obs_din !== e.w || obs_ml !== e.l) begin
          errors++; $display("FAIL mid_reset_drain: idx %0d got %h/%b want %h/%b", i, obs_din, obs_ml, e.w, e.l);
        end
      end
    end
    sb.delete();
  endtask

`ifdef FLIT_SER_BSWAP_EN
  task automatic test_bswap();
    logic [FLIT_W-1:0] d;
    d = rand_flit();
    d[31:0] = 32'h1122_3344;
    step(1'b1, d, 1'b0, 1'b0);
    checks++;
    if (sha_din !== 32'h4433_2211) begin errors++; $display("FAIL bswap_word0: got %h want 44332211", sha_din); end
    for (int i = 0; i < WORDS; i++) step(1'b0, '0, 1'b0, 1'b1);
    sb.delete();
  endtask
`endif

  initial begin
    reset        = 1'b1;
    flit_valid   = 1'b0;
    flit_data    = '0;
    flit_last    = 1'b0;
    sha_src_read = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    test_single_flit();
    test_back_to_back();
    test_simul_push_pop();
    test_read_empty();
    test_reset_mid();
`ifdef FLIT_SER_BSWAP_EN
    test_bswap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
